// File: rtl/uart_8n1_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding, oversampling
// constants and the 3-way majority vote used by the optional glitch filter.
package uart_8n1_rx_pkg;

  localparam int unsigned UART_8N1_OVERSAMPLE = 16;
  localparam int unsigned UART_8N1_MID_SAMPLE = 7;
  localparam int unsigned UART_8N1_DATA_BITS  = 8;

  localparam logic [3:0] RX_TICK_LAST = 4'(UART_8N1_OVERSAMPLE - 1);
  localparam logic [3:0] RX_TICK_MID  = 4'(UART_8N1_MID_SAMPLE);
  localparam logic [2:0] RX_BIT_LAST  = 3'(UART_8N1_DATA_BITS - 1);

  typedef enum logic [2:0] {
    UART_8N1_RX_IDLE  = 3'd0,
    UART_8N1_RX_START = 3'd1,
    UART_8N1_RX_DATA  = 3'd2,
    UART_8N1_RX_STOP  = 3'd3,
    UART_8N1_RX_BREAK = 3'd4
  } rx_state_e;

  // Two-out-of-three vote over a 3-sample history.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_8n1_rx_sync.sv
// uart_8n1_sync: STAGES-deep flop chain bringing an asynchronous line into the
// local clock domain. Resets to 1 so an idle-high serial line never looks like
// a start bit straight out of reset.
module uart_8n1_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_8n1_rx.sv
// uart_8n1_rx: 8N1 UART receiver clocked at 16x baud. Start bit is confirmed
// at mid-bit, data bits sampled 16 ticks apart LSB-first, stop bit checked,
// byte handed over on a valid/ready port with sticky overrun.
// Optional build macro UART_8N1_RX_MAJORITY_EN: every sample point takes the
// majority of a 3-deep rx history instead of the single current sample.
module uart_8n1_rx
  import uart_8n1_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_baud_16x,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_error,
  output logic       overrun
);

  logic rx_s;
  logic sample_s;
  logic deliver_s;
  logic accept_s;

  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       fe_q, fe_d;
  logic       ovr_q, ovr_d;

  uart_8n1_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_baud_16x),
    .reset_i (reset),
    .async_i (rx),
    .sync_o  (rx_s)
  );

`ifdef UART_8N1_RX_MAJORITY_EN
  logic [2:0] hist_q;

  // Keep the last three synchronised rx values for the majority vote.
  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], rx_s};
    end
  end

  assign sample_s = maj3(hist_q);
`else
  assign sample_s = rx_s;
`endif

  // Frame FSM next-state plus output buffer update.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    fe_d      = 1'b0;
    deliver_s = 1'b0;
    accept_s  = valid_q & data_ready;

    case (state_q)
      UART_8N1_RX_IDLE: begin
        if (!rx_s) begin
          state_d = UART_8N1_RX_START;
          tick_d  = 4'd0;
        end else begin
          tick_d  = 4'd0;
        end
      end
      UART_8N1_RX_START: begin
        if (tick_q == RX_TICK_MID) begin
          tick_d = 4'd0;
          if (!sample_s) begin
            state_d = UART_8N1_RX_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = UART_8N1_RX_IDLE;
          end
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end
      UART_8N1_RX_DATA: begin
        // 15 + 1 wraps to 0, so the next bit period restarts on its own.
        tick_d = tick_q + 4'd1;
        if (tick_q == RX_TICK_LAST) begin
          shift_d = {sample_s, shift_q[7:1]};
          if (bit_q == RX_BIT_LAST) begin
            state_d = UART_8N1_RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      UART_8N1_RX_STOP: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == RX_TICK_LAST) begin
          if (sample_s) begin
            deliver_s = 1'b1;
            state_d   = UART_8N1_RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = UART_8N1_RX_BREAK;
          end
        end else begin
          fe_d = 1'b0;
        end
      end
      UART_8N1_RX_BREAK: begin
        // Line held low after a bad stop bit: do not treat it as a new start.
        tick_d = 4'd0;
        if (rx_s) begin
          state_d = UART_8N1_RX_IDLE;
        end else begin
          state_d = UART_8N1_RX_BREAK;
        end
      end
      default: begin
        state_d = UART_8N1_RX_IDLE;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
      end
    endcase

    if (deliver_s && (!valid_q || data_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (accept_s) begin
        ovr_d = 1'b0;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (deliver_s) begin
      ovr_d = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      state_q <= UART_8N1_RX_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = fe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_8n1_rx.sv
// Directed bench for uart_8n1_rx: drives 8N1 frames tick by tick at the 16x
// clock and checks delivered bytes, latency, framing errors and overrun.
// Expected byte for the glitch frame depends on UART_8N1_RX_MAJORITY_EN.
module tb_uart_8n1_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_error;
  logic       overrun;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  logic [7:0] last_data = 8'h00;
  int         first_valid_c = -1;
  int         v0, f0, fv_save;

  uart_8n1_rx #(.SYNC_STAGES(2)) dut (
    .clk_baud_16x (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle: count valid / frame_error cycles, keep last byte.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= data;
    end
    if (frame_error) begin
      fe_cnt <= fe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tick per negedge: c 0..15 start, 16..143 data LSB first, 144..159 stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input int glitch_c, input int len);
    logic       v;
    logic [2:0] bi;
    first_valid_c = -1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (data_valid && first_valid_c < 0) first_valid_c = c;
      if (c < 16) begin
        v = 1'b0;
      end else if (c < 144) begin
        bi = 3'((c - 16) / 16);
        v  = b[bi];
      end else begin
        v = stop_b;
      end
      if (c == glitch_c) v = 1'b0;
      rx = v;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] glitch_exp;
`ifdef UART_8N1_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFB;
`endif
    reset = 1'b1;
    rx = 1'b1;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    settle();
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_fe", 32'(frame_error), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(10);

    // 1: clean 0x55, consumer always ready
    data_ready = 1'b1;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b1, -1, 160);
    idle(4);
    settle();
    check("t1_data", 32'(last_data), 32'h55);
    check("t1_valid_cycles", 32'(valid_cnt - v0), 32'd1);
    check("t1_latency", 32'(first_valid_c), 32'd155);
    check("t1_fe", 32'(fe_cnt - f0), 32'd0);
    check("t1_ovr", 32'(overrun), 32'h0);

    // 2: short low pulse is rejected as a glitch
    v0 = valid_cnt; f0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(60);
    settle();
    check("t2_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t2_no_fe", 32'(fe_cnt - f0), 32'd0);

    // 3: bad stop bit then line held low (break)
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'hA3, 1'b0, -1, 160);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    settle();
    check("t3_fe_once", 32'(fe_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
    idle(20);
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1, -1, 160);
    idle(4);
    settle();
    check("t3_after_break_data", 32'(last_data), 32'h81);
    check("t3_after_break_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t3_after_break_lat", 32'(first_valid_c), 32'd155);

    // 4: two bytes back to back with consumer stalled
    data_ready = 1'b0;
    idle(10);
    send_frame(8'h11, 1'b1, -1, 160);
    fv_save = first_valid_c;
    send_frame(8'h22, 1'b1, -1, 160);
    settle();
    check("t4_lat_first", 32'(fv_save), 32'd155);
    check("t4_data_kept", 32'(data), 32'h11);
    check("t4_valid_held", 32'(data_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    @(negedge clk);
    data_ready = 1'b1;
    settle();
    check("t4_accept_valid", 32'(data_valid), 32'h0);
    check("t4_accept_ovr", 32'(overrun), 32'h0);

    // 5: buffer a byte, then reset in the middle of a 0xFF frame
    @(negedge clk);
    data_ready = 1'b0;
    idle(10);
    send_frame(8'hC3, 1'b1, -1, 160);
    settle();
    check("t5_pre_data", 32'(data), 32'hC3);
    check("t5_pre_valid", 32'(data_valid), 32'h1);
    send_frame(8'hFF, 1'b1, -1, 80);
    @(negedge clk);
    reset = 1'b1;
    settle();
    check("t5_rst_data", 32'(data), 32'h00);
    check("t5_rst_valid", 32'(data_valid), 32'h0);
    check("t5_rst_ovr", 32'(overrun), 32'h0);
    check("t5_rst_fe", 32'(frame_error), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    data_ready = 1'b1;
    idle(20);
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b1, -1, 160);
    idle(4);
    settle();
    check("t5_post_data", 32'(last_data), 32'h3C);
    check("t5_post_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t5_post_lat", 32'(first_valid_c), 32'd155);

    // 6: one-tick low glitch at the bit-2 sample point of 0xFF
    idle(10);
    v0 = valid_cnt;
    send_frame(8'hFF, 1'b1, 56, 160);
    idle(4);
    settle();
    check("t6_glitch_data", 32'(last_data), 32'(glitch_exp));
    check("t6_glitch_cnt", 32'(valid_cnt - v0), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
